// File: rtl/p_hardisc.sv
// rtl/p_hardisc.sv - shared types and constants for the carry-less multiply sequencer
package p_hardisc;

  typedef enum logic [1:0] {
    CLMUL_L    = 2'b00,
    CLMUL_H    = 2'b01,
    CLMUL_R    = 2'b10,
    CLMUL_RSVD = 2'b11
  } clmul_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } clmul_state_t;

  localparam int CLMUL_ITER = 32;

  // Pick the 32-bit result window out of the 64-bit carry-less product
  function automatic logic [31:0] clmul_select(input clmul_mode_t mode, input logic [63:0] acc);
    logic [31:0] res;
    case (mode)
      CLMUL_L: res = acc[31:0];
      CLMUL_H: res = acc[63:32];
      CLMUL_R: res = acc[62:31];
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/beu_clmul_step.sv
// rtl/beu_clmul_step.sv - one combinational shift-and-xor iteration of carry-less multiply
module beu_clmul_step (
  input  logic [63:0] acc_i,
  input  logic [63:0] mcand_i,
  input  logic [31:0] mplr_i,
  output logic [63:0] acc_o,
  output logic [63:0] mcand_o,
  output logic [31:0] mplr_o
);

  // Conditionally fold the shifted multiplicand into the product, then advance one bit
  always_comb begin
    acc_o   = mplr_i[0] ? (acc_i ^ mcand_i) : acc_i;
    mcand_o = {mcand_i[62:0], 1'b0};
    mplr_o  = {1'b0, mplr_i[31:1]};
  end

endmodule

// File: rtl/beu_clmul_seq.sv
// rtl/beu_clmul_seq.sv - bit-serial CLMUL/CLMULH/CLMULR sequencer (optional BEU_CLMUL_EARLY_EXIT_EN)
module beu_clmul_seq
  import p_hardisc::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             s_clk_i,
  input  logic             s_reset_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [1:0]       s_mode_i,
  input  logic [31:0]      s_op1_i,
  input  logic [31:0]      s_op2_i,
  input  logic [TAG_W-1:0] s_tag_i,
  input  logic             s_flush_i,
  output logic             s_valid_o,
  input  logic             s_ready_i,
  output logic [31:0]      s_result_o,
  output logic [TAG_W-1:0] s_tag_o,
  output logic             s_busy_o
);

  clmul_state_t     state_q, state_d;
  clmul_mode_t      mode_q;
  logic [TAG_W-1:0] tag_q;
  logic [63:0]      acc_q, mcand_q;
  logic [31:0]      mplr_q;
  logic [4:0]       cnt_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] res_tag_q;

  logic [63:0] acc_n, mcand_n;
  logic [31:0] mplr_n;
  logic        accept;
  logic        last_iter;

  beu_clmul_step u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mplr_i  (mplr_q),
    .acc_o   (acc_n),
    .mcand_o (mcand_n),
    .mplr_o  (mplr_n)
  );

  assign s_ready_o  = (state_q == IDLE) & ~s_flush_i;
  assign accept     = s_valid_i & s_ready_o;
  assign s_valid_o  = (state_q == DONE);
  assign s_busy_o   = (state_q != IDLE);
  assign s_result_o = result_q;
  assign s_tag_o    = res_tag_q;

  // Decide whether the current RUN cycle is the final iteration
  always_comb begin
`ifdef BEU_CLMUL_EARLY_EXIT_EN
    last_iter = (cnt_q == 5'(CLMUL_ITER - 1)) || (mplr_n == 32'h0);
`else
    last_iter = (cnt_q == 5'(CLMUL_ITER - 1));
`endif
  end

  // Sequencer state register
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; flush overrides everything and returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    if (s_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (s_flush_i) state_d = IDLE;
  end

  // Operand capture, iteration datapath and registered result
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      mode_q    <= CLMUL_L;
      tag_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      res_tag_q <= '0;
    end else begin
      if (accept) begin
        mode_q  <= clmul_mode_t'(s_mode_i);
        tag_q   <= s_tag_i;
        acc_q   <= '0;
        mcand_q <= {32'h0, s_op1_i};
        mplr_q  <= s_op2_i;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q   <= acc_n;
        mcand_q <= mcand_n;
        mplr_q  <= mplr_n;
        cnt_q   <= cnt_q + 5'd1;
      end
      if ((state_q == RUN) && last_iter && !s_flush_i) begin
        result_q  <= clmul_select(mode_q, acc_n);
        res_tag_q <= tag_q;
      end
    end
  end

endmodule
